// File: rtl/id_stage.sv
// RV32I decode stage: registers the fetched word, decodes fields/immediate, flags illegal words,
// and uses a one-entry skid so if_ready comes straight from a flop. Optional: ID_STATS_EN.
module id_stage #(
    parameter int unsigned XLEN = 32
`ifdef ID_STATS_EN
    ,
    parameter int unsigned CNT_W = 32
`endif
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            if_valid,
    input  logic [31:0]     if_instr,
    input  logic [XLEN-1:0] if_pc,
    output logic            if_ready,
    input  logic            flush,
    input  logic            ex_ready,
    output logic            id_valid,
    output logic [XLEN-1:0] id_pc,
    output logic [31:0]     id_instr,
    output logic [6:0]      id_opcode,
    output logic [4:0]      id_rd,
    output logic [2:0]      id_funct3,
    output logic [4:0]      id_rs1,
    output logic [4:0]      id_rs2,
    output logic [6:0]      id_funct7,
    output logic [31:0]     id_imm,
    output logic [2:0]      id_fmt,
    output logic            id_illegal
`ifdef ID_STATS_EN
    ,
    output logic [CNT_W-1:0] stat_retired,
    output logic [CNT_W-1:0] stat_stall
`endif
);

    localparam logic [6:0] OpcodeOp     = 7'b0110011;
    localparam logic [6:0] OpcodeOpImm  = 7'b0010011;
    localparam logic [6:0] OpcodeLoad   = 7'b0000011;
    localparam logic [6:0] OpcodeJalr   = 7'b1100111;
    localparam logic [6:0] OpcodeSystem = 7'b1110011;
    localparam logic [6:0] OpcodeFence  = 7'b0001111;
    localparam logic [6:0] OpcodeStore  = 7'b0100011;
    localparam logic [6:0] OpcodeBranch = 7'b1100011;
    localparam logic [6:0] OpcodeLui    = 7'b0110111;
    localparam logic [6:0] OpcodeAuipc  = 7'b0010111;
    localparam logic [6:0] OpcodeJal    = 7'b1101111;

    localparam logic [2:0] FmtR    = 3'd0;
    localparam logic [2:0] FmtI    = 3'd1;
    localparam logic [2:0] FmtS    = 3'd2;
    localparam logic [2:0] FmtB    = 3'd3;
    localparam logic [2:0] FmtU    = 3'd4;
    localparam logic [2:0] FmtJ    = 3'd5;
    localparam logic [2:0] FmtNone = 3'd6;

    logic        accept;
    logic        retire;

    logic [31:0] dec_imm;
    logic [2:0]  dec_fmt;
    logic        dec_illegal;

    logic            id_valid_q,   id_valid_d;
    logic            if_ready_q,   if_ready_d;
    logic [XLEN-1:0] pc_q,         pc_d;
    logic [31:0]     instr_q,      instr_d;
    logic [31:0]     imm_q,        imm_d;
    logic [2:0]      fmt_q,        fmt_d;
    logic            illegal_q,    illegal_d;

    logic            skid_valid_q,   skid_valid_d;
    logic [XLEN-1:0] skid_pc_q,      skid_pc_d;
    logic [31:0]     skid_instr_q,   skid_instr_d;
    logic [31:0]     skid_imm_q,     skid_imm_d;
    logic [2:0]      skid_fmt_q,     skid_fmt_d;
    logic            skid_illegal_q, skid_illegal_d;

    assign accept = if_valid & if_ready_q;
    assign retire = id_valid_q & ex_ready;

    always_comb begin
        dec_fmt     = FmtNone;
        dec_imm     = '0;
        dec_illegal = 1'b0;
        case (if_instr[6:0])
            OpcodeOp: begin
                dec_fmt = FmtR;
                if (if_instr[31:25] == 7'b0100000) begin
                    dec_illegal = !((if_instr[14:12] == 3'b000) || (if_instr[14:12] == 3'b101));
                end else if (if_instr[31:25] != 7'b0000000) begin
                    dec_illegal = 1'b1;
                end
            end
            OpcodeOpImm, OpcodeLoad, OpcodeJalr, OpcodeSystem, OpcodeFence: begin
                dec_fmt = FmtI;
                dec_imm = {{20{if_instr[31]}}, if_instr[31:20]};
            end
            OpcodeStore: begin
                dec_fmt = FmtS;
                dec_imm = {{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
            end
            OpcodeBranch: begin
                dec_fmt = FmtB;
                dec_imm = {{19{if_instr[31]}}, if_instr[31], if_instr[7], if_instr[30:25],
                           if_instr[11:8], 1'b0};
            end
            OpcodeLui, OpcodeAuipc: begin
                dec_fmt = FmtU;
                dec_imm = {if_instr[31:12], 12'b0};
            end
            OpcodeJal: begin
                dec_fmt = FmtJ;
                dec_imm = {{11{if_instr[31]}}, if_instr[31], if_instr[19:12], if_instr[20],
                           if_instr[30:21], 1'b0};
            end
            default: dec_illegal = 1'b1;
        endcase
        if (if_instr[1:0] != 2'b11) begin
            dec_illegal = 1'b1;
        end
        // Illegal words still flow downstream, just with no format and a zero immediate.
        if (dec_illegal) begin
            dec_fmt = FmtNone;
            dec_imm = '0;
        end
    end

    always_comb begin
        id_valid_d     = id_valid_q;
        pc_d           = pc_q;
        instr_d        = instr_q;
        imm_d          = imm_q;
        fmt_d          = fmt_q;
        illegal_d      = illegal_q;
        skid_valid_d   = skid_valid_q;
        skid_pc_d      = skid_pc_q;
        skid_instr_d   = skid_instr_q;
        skid_imm_d     = skid_imm_q;
        skid_fmt_d     = skid_fmt_q;
        skid_illegal_d = skid_illegal_q;

        if (flush) begin
            id_valid_d   = 1'b0;
            skid_valid_d = 1'b0;
        end else if (skid_valid_q) begin
            // if_ready is low here, so only a retire can move anything.
            if (retire) begin
                pc_d         = skid_pc_q;
                instr_d      = skid_instr_q;
                imm_d        = skid_imm_q;
                fmt_d        = skid_fmt_q;
                illegal_d    = skid_illegal_q;
                skid_valid_d = 1'b0;
            end
        end else if (accept) begin
            if (!id_valid_q || ex_ready) begin
                pc_d       = if_pc;
                instr_d    = if_instr;
                imm_d      = dec_imm;
                fmt_d      = dec_fmt;
                illegal_d  = dec_illegal;
                id_valid_d = 1'b1;
            end else begin
                skid_pc_d      = if_pc;
                skid_instr_d   = if_instr;
                skid_imm_d     = dec_imm;
                skid_fmt_d     = dec_fmt;
                skid_illegal_d = dec_illegal;
                skid_valid_d   = 1'b1;
            end
        end else if (retire) begin
            id_valid_d = 1'b0;
        end

        if_ready_d = ~skid_valid_d;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            id_valid_q     <= 1'b0;
            if_ready_q     <= 1'b1;
            pc_q           <= '0;
            instr_q        <= '0;
            imm_q          <= '0;
            fmt_q          <= '0;
            illegal_q      <= 1'b0;
            skid_valid_q   <= 1'b0;
            skid_pc_q      <= '0;
            skid_instr_q   <= '0;
            skid_imm_q     <= '0;
            skid_fmt_q     <= '0;
            skid_illegal_q <= 1'b0;
        end else begin
            id_valid_q     <= id_valid_d;
            if_ready_q     <= if_ready_d;
            pc_q           <= pc_d;
            instr_q        <= instr_d;
            imm_q          <= imm_d;
            fmt_q          <= fmt_d;
            illegal_q      <= illegal_d;
            skid_valid_q   <= skid_valid_d;
            skid_pc_q      <= skid_pc_d;
            skid_instr_q   <= skid_instr_d;
            skid_imm_q     <= skid_imm_d;
            skid_fmt_q     <= skid_fmt_d;
            skid_illegal_q <= skid_illegal_d;
        end
    end

    assign if_ready   = if_ready_q;
    assign id_valid   = id_valid_q;
    assign id_pc      = pc_q;
    assign id_instr   = instr_q;
    assign id_opcode  = instr_q[6:0];
    assign id_rd      = instr_q[11:7];
    assign id_funct3  = instr_q[14:12];
    assign id_rs1     = instr_q[19:15];
    assign id_rs2     = instr_q[24:20];
    assign id_funct7  = instr_q[31:25];
    assign id_imm     = imm_q;
    assign id_fmt     = fmt_q;
    assign id_illegal = illegal_q;

`ifdef ID_STATS_EN
    logic [CNT_W-1:0] stat_retired_q, stat_retired_d;
    logic [CNT_W-1:0] stat_stall_q,   stat_stall_d;

    // Counters ignore flush; they only see the output handshake.
    always_comb begin
        stat_retired_d = stat_retired_q + CNT_W'(retire);
        stat_stall_d   = stat_stall_q + CNT_W'(id_valid_q & ~ex_ready);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stat_retired_q <= '0;
            stat_stall_q   <= '0;
        end else begin
            stat_retired_q <= stat_retired_d;
            stat_stall_q   <= stat_stall_d;
        end
    end

    assign stat_retired = stat_retired_q;
    assign stat_stall   = stat_stall_q;
`endif

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: directed decode/stall/flush/reset cases plus random traffic,
// checked against a queue model of the stage and a format-table decoder.
module tb_id_stage;

    logic        clock = 1'b0;
    logic        reset;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_ready;
    logic        flush;
    logic        ex_ready;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_instr;
    logic [6:0]  id_opcode;
    logic [4:0]  id_rd;
    logic [2:0]  id_funct3;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic [6:0]  id_funct7;
    logic [31:0] id_imm;
    logic [2:0]  id_fmt;
    logic        id_illegal;
`ifdef ID_STATS_EN
    logic [31:0] stat_retired;
    logic [31:0] stat_stall;
    logic [31:0] m_retired;
    logic [31:0] m_stall;
`endif

    always #5 clock = ~clock;

    id_stage dut (
        .clock      (clock),
        .reset      (reset),
        .if_valid   (if_valid),
        .if_instr   (if_instr),
        .if_pc      (if_pc),
        .if_ready   (if_ready),
        .flush      (flush),
        .ex_ready   (ex_ready),
        .id_valid   (id_valid),
        .id_pc      (id_pc),
        .id_instr   (id_instr),
        .id_opcode  (id_opcode),
        .id_rd      (id_rd),
        .id_funct3  (id_funct3),
        .id_rs1     (id_rs1),
        .id_rs2     (id_rs2),
        .id_funct7  (id_funct7),
        .id_imm     (id_imm),
        .id_fmt     (id_fmt),
        .id_illegal (id_illegal)
`ifdef ID_STATS_EN
        ,
        .stat_retired (stat_retired),
        .stat_stall   (stat_stall)
`endif
    );

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } entry_t;

    // Stage contents in order: at most two entries (output register + skid).
    entry_t model_q[$];
    int n_checks = 0;
    int n_errors = 0;

    logic [6:0] legal_ops [11] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011,
                                   7'b0001111, 7'b0100011, 7'b1100011, 7'b0110111, 7'b0010111,
                                   7'b1101111};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic void ref_decode(input logic [31:0] w, output logic [31:0] imm,
                                       output logic [2:0] fmt, output logic ill);
        logic [31:0] t;
        ill = 1'b0;
        fmt = 3'd6;
        imm = '0;
        case (w[6:0])
            7'b0110011: begin
                fmt = 3'd0;
                ill = !((w[31:25] == 7'b0) ||
                        (w[31:25] == 7'b0100000 && (w[14:12] == 3'b000 || w[14:12] == 3'b101)));
            end
            7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011, 7'b0001111: begin
                fmt = 3'd1;
                t = {w[31:20], 20'b0};
                imm = $signed(t) >>> 20;
            end
            7'b0100011: begin
                fmt = 3'd2;
                t = {w[31:25], w[11:7], 20'b0};
                imm = $signed(t) >>> 20;
            end
            7'b1100011: begin
                fmt = 3'd3;
                t = {w[31], w[7], w[30:25], w[11:8], 1'b0, 19'b0};
                imm = $signed(t) >>> 19;
            end
            7'b0110111, 7'b0010111: begin
                fmt = 3'd4;
                imm = {w[31:12], 12'b0};
            end
            7'b1101111: begin
                fmt = 3'd5;
                t = {w[31], w[19:12], w[20], w[30:21], 1'b0, 11'b0};
                imm = $signed(t) >>> 11;
            end
            default: ill = 1'b1;
        endcase
        if (ill) begin
            fmt = 3'd6;
            imm = '0;
        end
    endfunction

    task automatic check_outputs();
        logic [31:0] imm;
        logic [2:0]  fmt;
        logic        ill;
        logic [31:0] w;
        check("id_valid", 32'(id_valid), 32'(model_q.size() > 0));
        check("if_ready", 32'(if_ready), 32'(model_q.size() < 2));
        if (model_q.size() > 0) begin
            w = model_q[0].instr;
            ref_decode(w, imm, fmt, ill);
            check("id_pc", id_pc, model_q[0].pc);
            check("id_instr", id_instr, w);
            check("id_imm", id_imm, imm);
            check("id_fmt", 32'(id_fmt), 32'(fmt));
            check("id_illegal", 32'(id_illegal), 32'(ill));
            check("id_fields", {id_funct7, id_rs2, id_rs1, id_funct3, id_rd, id_opcode}, w);
        end
`ifdef ID_STATS_EN
        check("stat_retired", stat_retired, m_retired);
        check("stat_stall", stat_stall, m_stall);
`endif
    endtask

    // Drive one cycle, advance the model across the edge, then compare at the falling edge.
    task automatic drive(input logic v, input logic [31:0] w, input logic [31:0] pc,
                         input logic rdy, input logic fl);
        entry_t e;
        logic   full;
        logic   ret;
        if_valid = v;
        if_instr = w;
        if_pc    = pc;
        ex_ready = rdy;
        flush    = fl;
        @(posedge clock);
        full = model_q.size() >= 2;
        ret  = model_q.size() > 0 && rdy;
`ifdef ID_STATS_EN
        if (ret) m_retired++;
        if (model_q.size() > 0 && !rdy) m_stall++;
`endif
        if (fl) begin
            model_q.delete();
        end else begin
            if (ret) void'(model_q.pop_front());
            if (v && !full) begin
                e.instr = w;
                e.pc    = pc;
                model_q.push_back(e);
            end
        end
        @(negedge clock);
        check_outputs();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        check("rst id_valid", 32'(id_valid), 32'd0);
        check("rst if_ready", 32'(if_ready), 32'd1);
        check("rst id_imm", id_imm, 32'd0);
        model_q.delete();
`ifdef ID_STATS_EN
        m_retired = '0;
        m_stall   = '0;
`endif
        @(negedge clock);
        reset = 1'b0;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        int k;
        w = $urandom();
        k = $urandom_range(0, 13);
        if (k < 11) begin
            w[6:0] = legal_ops[k];
            if (k == 0 && $urandom_range(0, 1) == 1) begin
                w[31:25] = ($urandom_range(0, 1) == 1) ? 7'b0100000 : 7'b0000000;
            end
        end
        return w;
    endfunction

    initial begin
        reset    = 1'b1;
        if_valid = 1'b0;
        if_instr = '0;
        if_pc    = '0;
        flush    = 1'b0;
        ex_ready = 1'b0;
`ifdef ID_STATS_EN
        m_retired = '0;
        m_stall   = '0;
`endif
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        check_outputs();
        check("rst id_pc", id_pc, 32'd0);

        drive(1'b1, 32'h0050_0093, 32'h10, 1'b1, 1'b0);
        check("addi rd", 32'(id_rd), 32'd1);
        check("addi rs1", 32'(id_rs1), 32'd0);
        check("addi imm", id_imm, 32'd5);
        check("addi fmt", 32'(id_fmt), 32'd1);
        check("addi pc", id_pc, 32'h10);

        drive(1'b1, 32'hFE20_8EE3, 32'h14, 1'b1, 1'b0);
        check("beq imm", id_imm, 32'hFFFF_FFFC);
        check("beq fmt", 32'(id_fmt), 32'd3);
        check("beq rs", {27'd0, id_rs1}, 32'd1);
        check("beq rs2", {27'd0, id_rs2}, 32'd2);
        drive(1'b1, 32'h0051_2423, 32'h18, 1'b1, 1'b0);
        check("sw imm", id_imm, 32'd8);
        check("sw rs1/rs2", {id_rs1, id_rs2}, {22'd0, 5'd2, 5'd5});
        check("sw fmt", 32'(id_fmt), 32'd2);
        drive(1'b1, 32'h1234_51B7, 32'h1C, 1'b1, 1'b0);
        check("lui rd", 32'(id_rd), 32'd3);
        check("lui imm", id_imm, 32'h1234_5000);
        check("lui fmt", 32'(id_fmt), 32'd4);

        do_reset();
        drive(1'b1, 32'hFFFF_FFFF, 32'h20, 1'b1, 1'b0);
        check("ill0", {28'd0, id_illegal, id_fmt}, 32'hE);
        drive(1'b1, 32'h0000_0000, 32'h24, 1'b1, 1'b0);
        check("ill1", {28'd0, id_illegal, id_fmt}, 32'hE);
        drive(1'b1, 32'h4000_1033, 32'h28, 1'b1, 1'b0);
        check("ill2", {28'd0, id_illegal, id_fmt}, 32'hE);
        check("ill2 imm", id_imm, 32'd0);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
`ifdef ID_STATS_EN
        check("stat_retired=3", stat_retired, 32'd3);
`endif

        // Back-pressure: second word goes to skid, third is held off.
        drive(1'b1, 32'h0010_0113, 32'h40, 1'b0, 1'b0);
        drive(1'b1, 32'h0020_0193, 32'h44, 1'b0, 1'b0);
        check("stall if_ready", 32'(if_ready), 32'd0);
        drive(1'b1, 32'h0030_0213, 32'h48, 1'b0, 1'b0);
        check("stall hold", id_instr, 32'h0010_0113);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        check("skid drain", id_instr, 32'h0020_0193);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Flush with skid full and a word on offer.
        drive(1'b1, 32'h0040_0293, 32'h50, 1'b0, 1'b0);
        drive(1'b1, 32'h0050_0313, 32'h54, 1'b0, 1'b0);
        drive(1'b1, 32'h0060_0393, 32'h58, 1'b0, 1'b1);
        check("flush id_valid", 32'(id_valid), 32'd0);
        check("flush if_ready", 32'(if_ready), 32'd1);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Reset while stalled with both entries full.
        drive(1'b1, 32'h0070_0413, 32'h60, 1'b0, 1'b0);
        drive(1'b1, 32'h0080_0493, 32'h64, 1'b0, 1'b0);
        do_reset();
        check_outputs();

        for (int i = 0; i < 2000; i++) begin
            drive($urandom_range(0, 3) != 0, rand_instr(), $urandom() & 32'hFFFF_FFFC,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- RV32I instruction-decode stage directly downstream of the fetch unit.
- Registers the fetched instruction and its PC, decodes fields and the sign-extended immediate, and flags illegal encodings.
- Includes a one-entry skid buffer, so fetch back-pressure (if_ready) is driven straight from a flop.
- Feeds the execute stage through a valid/ready handshake.

Parameters:
- XLEN, 32, datapath/PC width; only 32 is supported.
- CNT_W, 32, width of the statistics counters (optional feature only).

Ports:
- clock  in  1  system clock
- reset  in  1  reset
- if_valid  in  1  fetch presents an instruction
- if_instr  in  32  fetched instruction word
- if_pc  in  32  PC of if_instr
- if_ready  out  1  stage can accept; equals NOT skid_valid, registered
- flush  in  1  synchronous squash (branch/jump redirect)
- ex_ready  in  1  execute stage accepts id outputs
- id_valid  out  1  decoded instruction valid
- id_pc  out  32  registered PC
- id_instr  out  32  registered raw instruction
- id_opcode  out  7  instr[6:0]
- id_rd  out  5  instr[11:7]
- id_funct3  out  3  instr[14:12]
- id_rs1  out  5  instr[19:15]
- id_rs2  out  5  instr[24:20]
- id_funct7  out  7  instr[31:25]
- id_imm  out  32  sign-extended immediate
- id_fmt  out  3  0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 6=none
- id_illegal  out  1  illegal encoding

Behaviour:
- Clock and reset: clock is clock; reset is asynchronous, active-high.
- Reset state:
  - All output registers, skid registers, id_valid and skid_valid clear to 0.
  - if_ready = 1 after reset deasserts.
- Decode:
  - Decode is combinational on the incoming word; results are stored with the word. Latency is 1 cycle from accept to id_valid.
  - The skid entry stores already-decoded fields.
- Accept and retire:
  - Input accept = if_valid & if_ready.
  - Output retire = id_valid & ex_ready.
- Register update, skid empty:
  - On accept, if !id_valid or ex_ready: output regs load the new instruction; id_valid=1.
  - On accept, if id_valid and !ex_ready: the new instruction loads into skid; skid_valid=1.
  - No accept and retire: id_valid=0.
- Register update, skid full:
  - if_ready=0, so no accept occurs.
  - On retire: output regs load from skid; skid_valid=0; id_valid stays 1.
  - No retire: hold everything.
- Stall: id_* outputs are stable while id_valid & !ex_ready.
- Flush:
  - Has highest priority: next cycle id_valid=0 and skid_valid=0.
  - An instruction offered in the same cycle is dropped.
  - Data regs may hold stale values.
- Immediate formats:
  - I: sext(instr[31:20]); applies to opcodes 0010011, 0000011, 1100111, 1110011, 0001111.
  - S: sext({instr[31:25], instr[11:7]}).
  - B: sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
  - U: {instr[31:12], 12'b0}; applies to 0110111 and 0010111.
  - J: sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
  - R: 0110011 gives imm=0.
- Illegal conditions:
  - instr[1:0] != 2'b11.
  - Opcode outside the 11 RV32I opcodes listed above.
  - R-type funct7 not in {0000000, 0100000}.
  - R-type funct7=0100000 with funct3 not in {000, 101}.
  - Illegal words get id_fmt=6 and imm=0, and still flow with id_valid=1.
- Reset mid-stall clears both entries immediately.

Optional Feature:
- Macro: ID_STATS_EN.
- When defined:
  - Adds outputs stat_retired [CNT_W-1:0], incremented on each retire.
  - Adds stat_stall [CNT_W-1:0], incremented each cycle id_valid & !ex_ready.
  - Both counters reset to 0, wrap modulo 2^CNT_W, and are unaffected by flush.
- When undefined: the ports and logic are absent.

Test Plan:
- Reset asserted mid-stream -> id_valid=0, if_ready=1, id_imm=0 immediately.
- if_instr=0x00500093, pc=0x10, ex_ready=1 -> next cycle id_valid=1, rd=1, rs1=0, imm=5, fmt=1, illegal=0, id_pc=0x10.
- Stream 0xFE208EE3, 0x00512423, 0x123451B7 -> expected decodes:
  - beq: imm=0xFFFFFFFC, fmt=3, rs1=1, rs2=2.
  - sw: imm=8, rs1=2, rs2=5, fmt=2.
  - lui: rd=3, imm=0x12345000, fmt=4.
- Hold ex_ready=0 with 3 back-to-back inputs -> second goes to skid, if_ready=0 next cycle, third held off.
  - Release ex_ready: order preserved, none lost or duplicated.
- Full skid, then flush=1 with if_valid=1 -> next cycle id_valid=0, if_ready=1, flushed input never appears.
- 0xFFFFFFFF, 0x00000000, 0x40001033 (funct7=0100000, funct3=001) -> id_illegal=1 for each, fmt=6; with ID_STATS_EN, stat_retired=3.
